// File: rtl/riscv_boot_ctrl.sv
// Boot sequencer: streams a length-prefixed image into instruction memory,
// then releases the core until a halt instruction, a PC fault or a timeout.
module riscv_boot_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CYC_W      = 16,
    parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [CYC_W-1:0]  cycle_count
);
    localparam int unsigned LEN_W    = 16;
    localparam int unsigned IDX_W    = ADDR_W + 1;
    localparam int unsigned CAPACITY = 32'd1 << ADDR_W;
    // PC bits allowed to be set: word-aligned and inside the memory
    localparam logic [31:0] PC_OK_MASK     = ((32'd1 << ADDR_W) - 32'd1) << 2;
    localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;
    localparam logic [1:0]  ERR_NONE       = 2'd0;
    localparam logic [1:0]  ERR_LEN        = 2'd1;
    localparam logic [1:0]  ERR_PC         = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT    = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        LOAD,
        RUN,
        HALT,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [23:0]        asm_q, asm_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic               last_wr_q, last_wr_d;

    logic               s_ready_d;
    logic               we_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [31:0]        wdata_d;
    logic               run_d;
    logic               busy_d;
    logic               done_d;
    logic               error_d;
    logic [1:0]         code_d;
    logic [CYC_W-1:0]   cyc_d;

    logic               xfer;
    logic [LEN_W-1:0]   len_full;
    logic               halt_hit;
    logic               pc_bad;

    // State and every output are registered together
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            asm_q       <= '0;
            bcnt_q      <= '0;
            widx_q      <= '0;
            last_wr_q   <= 1'b0;
            s_ready     <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            core_run    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            bcnt_q      <= bcnt_d;
            widx_q      <= widx_d;
            last_wr_q   <= last_wr_d;
            s_ready     <= s_ready_d;
            imem_we     <= we_d;
            imem_addr   <= addr_d;
            imem_wdata  <= wdata_d;
            core_run    <= run_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
            err_code    <= code_d;
            cycle_count <= cyc_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        asm_d     = asm_q;
        bcnt_d    = bcnt_q;
        widx_d    = widx_q;
        last_wr_d = 1'b0;
        we_d      = 1'b0;
        addr_d    = imem_addr;
        wdata_d   = imem_wdata;
        code_d    = err_code;
        cyc_d     = cycle_count;
        xfer      = s_valid & s_ready;
        len_full  = {s_data, len_q[7:0]};
        halt_hit  = (instr == INSTR_EBREAK) || (instr == INSTR_JAL_SELF);
        pc_bad    = (pc & ~PC_OK_MASK) != 32'd0;

        case (state_q)
            IDLE, HALT, ERR: begin
                if (start) begin
                    state_d = HDR0;
                    code_d  = ERR_NONE;
                    cyc_d   = '0;
                    widx_d  = '0;
                    bcnt_d  = '0;
                    asm_d   = '0;
                end
            end
            HDR0: begin
                if (xfer) begin
                    len_d[7:0] = s_data;
                    state_d    = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == '0 || 32'(len_full) > CAPACITY) begin
                        state_d = ERR;
                        code_d  = ERR_LEN;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last_wr_q) begin
                    state_d = RUN;
                end else if (xfer) begin
                    if (bcnt_q == 2'd3) begin
                        we_d      = 1'b1;
                        addr_d    = widx_q[ADDR_W-1:0];
                        wdata_d   = {s_data, asm_q};
                        widx_d    = widx_q + IDX_W'(1);
                        bcnt_d    = 2'd0;
                        last_wr_d = (32'(widx_q) + 32'd1) == 32'(len_q);
                    end else begin
                        case (bcnt_q)
                            2'd0:    asm_d[7:0]   = s_data;
                            2'd1:    asm_d[15:8]  = s_data;
                            default: asm_d[23:16] = s_data;
                        endcase
                        bcnt_d = bcnt_q + 2'd1;
                    end
                end
            end
            RUN: begin
                if (halt_hit) begin
                    state_d = HALT;
                end else if (pc_bad) begin
                    state_d = ERR;
                    code_d  = ERR_PC;
                end else if (cycle_count == CYC_W'(MAX_CYCLES)) begin
                    state_d = ERR;
                    code_d  = ERR_TIMEOUT;
                end else if (cycle_count != '1) begin
                    cyc_d = cycle_count + CYC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The final write cycle already refuses bytes so none leak past the image
        s_ready_d = (state_d == HDR0 || state_d == HDR1 || state_d == LOAD) && !last_wr_d;
        run_d     = (state_d == RUN);
        busy_d    = (state_d == HDR0 || state_d == HDR1 || state_d == LOAD || state_d == RUN);
        done_d    = (state_d == HALT);
        error_d   = (state_d == ERR);
    end

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Randomised load/run bench for riscv_boot_ctrl, checked every cycle against a
// byte-count reference model plus a few hand-computed end-of-run expectations.
`timescale 1ns/1ps
module tb_riscv_boot_ctrl;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CYC_W  = 16;
    localparam int unsigned MAXC   = 20;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] JAL0   = 32'h0000_006F;

    typedef logic [7:0]  bytes_t[$];
    typedef logic [31:0] words_t[$];

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic              busy;
    logic              done;
    logic              error;
    logic [1:0]        err_code;
    logic [CYC_W-1:0]  cycle_count;

    always #5 clk = ~clk;

    riscv_boot_ctrl #(
        .ADDR_W    (ADDR_W),
        .CYC_W     (CYC_W),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .pc         (pc),
        .instr      (instr),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .cycle_count(cycle_count)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Expected outputs
    logic              exp_ready = 1'b0;
    logic              exp_we    = 1'b0;
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic [31:0]       exp_wdata = '0;
    logic              exp_run   = 1'b0;
    logic              exp_busy  = 1'b0;
    logic              exp_done  = 1'b0;
    logic              exp_error = 1'b0;
    logic [1:0]        exp_code  = '0;
    logic [CYC_W-1:0]  exp_cyc   = '0;

    // Simple core: PC held at 0 while not released, +4 per running cycle
    logic [31:0] mem [256];
    logic [31:0] core_pc = '0;
    logic        pc_force;
    logic [31:0] pc_force_val;
    logic        instr_force;
    logic [31:0] instr_force_val;
    assign pc    = pc_force ? pc_force_val : core_pc;
    assign instr = instr_force ? instr_force_val : mem[core_pc[9:2]];
    always @(posedge clk) core_pc <= exp_run ? core_pc + 32'd4 : 32'd0;

    // Reference model: everything follows from the number of bytes accepted since start
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3, M_ERR = 4;
    int          mode = M_IDLE;
    int          nacc;
    int          nlen;
    int          j;
    logic        go_run;
    logic [7:0]  lane_b [4];
    logic [31:0] w;

    always @(posedge clk) begin
        exp_we <= 1'b0;
        if (!reset) begin
            mode = M_IDLE;
            nacc = 0;
            go_run = 1'b0;
            exp_ready <= 1'b0; exp_addr <= '0; exp_wdata <= '0; exp_run <= 1'b0;
            exp_busy <= 1'b0; exp_done <= 1'b0; exp_error <= 1'b0; exp_code <= '0; exp_cyc <= '0;
        end else begin
            case (mode)
                M_IDLE, M_HALT, M_ERR: if (start) begin
                    mode = M_LOAD; nacc = 0; go_run = 1'b0;
                    exp_ready <= 1'b1; exp_busy <= 1'b1; exp_done <= 1'b0;
                    exp_error <= 1'b0; exp_code <= 2'd0; exp_cyc <= '0;
                end
                M_LOAD: if (go_run) begin
                    mode = M_RUN; go_run = 1'b0; exp_run <= 1'b1;
                end else if (s_valid && exp_ready) begin
                    if (nacc == 0) nlen = int'(s_data);
                    else if (nacc == 1) begin
                        nlen = nlen + 256 * int'(s_data);
                        if (nlen < 1 || nlen > (1 << ADDR_W)) begin
                            mode = M_ERR;
                            exp_ready <= 1'b0; exp_busy <= 1'b0; exp_error <= 1'b1; exp_code <= 2'd1;
                        end
                    end else begin
                        j = nacc - 2;
                        lane_b[j % 4] = s_data;
                        if (j % 4 == 3) begin
                            w = {lane_b[3], lane_b[2], lane_b[1], lane_b[0]};
                            exp_we <= 1'b1; exp_addr <= ADDR_W'(j / 4); exp_wdata <= w;
                            mem[j / 4] = w;
                            if (j / 4 == nlen - 1) begin go_run = 1'b1; exp_ready <= 1'b0; end
                        end
                    end
                    nacc++;
                end
                M_RUN: begin
                    if (instr == EBREAK || instr == JAL0) begin
                        mode = M_HALT; exp_run <= 1'b0; exp_busy <= 1'b0; exp_done <= 1'b1;
                    end else if (pc[1:0] != 2'b00 || pc >= (32'd4 << ADDR_W)) begin
                        mode = M_ERR; exp_run <= 1'b0; exp_busy <= 1'b0; exp_error <= 1'b1; exp_code <= 2'd2;
                    end else if (32'(exp_cyc) == MAXC) begin
                        mode = M_ERR; exp_run <= 1'b0; exp_busy <= 1'b0; exp_error <= 1'b1; exp_code <= 2'd3;
                    end else if (exp_cyc != 16'hFFFF) begin
                        exp_cyc <= exp_cyc + 16'd1;
                    end
                end
                default: mode = M_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic expire(input string name, input int waited);
        n_vec++;
        n_bad++;
        $display("FAIL %s: no completion after %0d cycles", name, waited);
    endtask

    // Per-cycle compare and write log
    logic [63:0] wlog[$];
    int          cyc_no = 0;
    int          last_we_cyc = 0;
    int          rise_cyc = 0;
    logic        prev_run = 1'b0;

    always @(negedge clk) begin
        cyc_no++;
        if (chk_en) begin
            check("s_ready",     32'(s_ready),     32'(exp_ready));
            check("imem_we",     32'(imem_we),     32'(exp_we));
            check("imem_addr",   32'(imem_addr),   32'(exp_addr));
            check("imem_wdata",  imem_wdata,       exp_wdata);
            check("core_run",    32'(core_run),    32'(exp_run));
            check("busy",        32'(busy),        32'(exp_busy));
            check("done",        32'(done),        32'(exp_done));
            check("error",       32'(error),       32'(exp_error));
            check("err_code",    32'(err_code),    32'(exp_code));
            check("cycle_count", 32'(cycle_count), 32'(exp_cyc));
        end
        if (imem_we) begin
            wlog.push_back({32'(imem_addr), imem_wdata});
            last_we_cyc = cyc_no;
        end
        if (core_run && !prev_run) rise_cyc = cyc_no;
        prev_run = core_run;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic bytes_t build(input words_t ws, input int n);
        bytes_t q;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        foreach (ws[i]) begin
            w = ws[i];
            for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
        end
        return q;
    endfunction

    function automatic logic [31:0] rand_word();
        int r = $urandom_range(0, 9);
        if (r < 6) return NOP;
        if (r == 6) return EBREAK;
        if (r == 7) return JAL0;
        return $urandom;
    endfunction

    // Offer bytes with optional random gaps; a byte moves on when valid&ready at the edge
    task automatic send(input bytes_t q, input int gap_pct, input bit poke);
        int i = 0;
        int spent = 0;
        bit hs;
        while (i < q.size()) begin
            start = poke && (i == 3);
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                s_valid = 1'b0; s_data = 8'($urandom);
            end else begin
                s_valid = 1'b1; s_data = q[i];
            end
            @(negedge clk);
            hs = s_valid && s_ready;
            tick();
            if (hs) i++;
            spent++;
            if (spent > 8 * q.size() + 64) begin
                expire("send", spent);
                break;
            end
        end
        start = 1'b0;
        s_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done || error) break;
        end
        if (k == budget) expire("wait_end", budget);
    endtask

    task automatic wait_run(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (core_run) break;
        end
        if (k == budget) expire("wait_run", budget);
    endtask

    initial begin
        bytes_t      bs;
        bytes_t      bs5;
        words_t      ws;
        logic [63:0] save[$];
        int          n;

        reset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        pc_force = 1'b0; pc_force_val = '0; instr_force = 1'b0; instr_force_val = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        reset = 1'b1;
        tick();

        // Two-word program ending in ebreak
        ws = '{32'h0050_0093, 32'h0010_0073};
        bs = build(ws, 2);
        wlog.delete();
        do_start();
        send(bs, 0, 1'b0);
        wait_end(100);
        check("t1_done", 32'(done), 32'd1);
        check("t1_run", 32'(core_run), 32'd0);
        check("t1_cycles", 32'(cycle_count), 32'd1);
        check("t1_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            check("t1_w0", wlog[0][31:0], 32'h0050_0093);
            check("t1_a1", wlog[1][63:32], 32'd1);
            check("t1_w1", wlog[1][31:0], 32'h0010_0073);
        end
        check("t1_run_after_we", 32'(rise_cyc - last_we_cyc), 32'd1);
        tick();

        // Bad lengths: 0 and 257
        wlog.delete();
        do_start();
        bs = '{8'h00, 8'h00};
        send(bs, 0, 1'b0);
        wait_end(50);
        check("t2_zero_code", 32'(err_code), 32'd1);
        check("t2_zero_err", 32'(error), 32'd1);
        tick();
        do_start();
        bs = '{8'h01, 8'h01};
        send(bs, 0, 1'b0);
        wait_end(50);
        check("t2_big_code", 32'(err_code), 32'd1);
        check("t2_run", 32'(core_run), 32'd0);
        check("t2_nwrites", 32'(wlog.size()), 32'd0);
        tick();

        // Full-capacity image of nops runs into the timeout
        ws.delete();
        for (int i = 0; i < 256; i++) ws.push_back(NOP);
        bs = build(ws, 256);
        wlog.delete();
        do_start();
        send(bs, 0, 1'b0);
        wait_end(100);
        check("cap_nwrites", 32'(wlog.size()), 32'd256);
        if (wlog.size() == 256) check("cap_last_addr", wlog[255][63:32], 32'd255);
        check("cap_code", 32'(err_code), 32'd3);
        tick();

        // Timeout with instr held at nop even though memory starts with ebreak
        instr_force = 1'b1; instr_force_val = NOP;
        ws = '{EBREAK};
        do_start();
        send(build(ws, 1), 0, 1'b0);
        wait_end(100);
        check("t4_code", 32'(err_code), 32'd3);
        check("t4_cycles", 32'(cycle_count), 32'd20);
        check("t4_run", 32'(core_run), 32'd0);
        instr_force = 1'b0;
        tick();

        // Same 3-word image with and without source gaps
        ws = '{$urandom, $urandom, $urandom};
        bs = build(ws, 3);
        wlog.delete();
        do_start();
        send(bs, 0, 1'b0);
        wait_end(100);
        save = wlog;
        tick();
        wlog.delete();
        do_start();
        send(bs, 50, 1'b1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 8'($urandom);
            @(negedge clk);
            check("t3_no_ready", 32'(s_ready), 32'd0);
            tick();
        end
        s_valid = 1'b0;
        wait_end(100);
        check("t3_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3 && save.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t3_same_as_gapfree", wlog[i][31:0], save[i][31:0]);
                check("t3_addr", wlog[i][63:32], 32'(i));
                check("t3_word", wlog[i][31:0], ws[i]);
            end
        end
        tick();

        // PC fault, then restart and a fresh load
        instr_force = 1'b1; instr_force_val = NOP;
        do_start();
        send(build('{NOP}, 1), 0, 1'b0);
        wait_run(20);
        tick(); tick();
        pc_force = 1'b1; pc_force_val = 32'h0000_0402;
        wait_end(20);
        check("t5_code", 32'(err_code), 32'd2);
        pc_force = 1'b0; instr_force = 1'b0;
        tick();
        do_start();
        @(negedge clk);
        check("t5_err_clr", 32'(error), 32'd0);
        check("t5_code_clr", 32'(err_code), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        tick();
        send(build('{32'h0050_0093, EBREAK}, 2), 0, 1'b0);
        wait_end(100);
        check("t5_reload_done", 32'(done), 32'd1);
        tick();

        // Reset mid-load, then reload restarts at word 0
        ws = '{rand_word(), rand_word(), rand_word()};
        bs = build(ws, 3);
        do_start();
        bs5 = bs[0:4];
        send(bs5, 0, 1'b0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("t6_load_rst_busy", 32'(busy), 32'd0);
        check("t6_load_rst_ready", 32'(s_ready), 32'd0);
        reset = 1'b1;
        tick();
        wlog.delete();
        do_start();
        send(bs, 0, 1'b0);
        wait_end(100);
        check("t6_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() > 0) check("t6_first_addr", wlog[0][63:32], 32'd0);
        tick();

        // Reset mid-run
        instr_force = 1'b1; instr_force_val = NOP;
        do_start();
        send(build('{NOP}, 1), 0, 1'b0);
        wait_run(20);
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("t6_run_rst_run", 32'(core_run), 32'd0);
        check("t6_run_rst_cyc", 32'(cycle_count), 32'd0);
        reset = 1'b1;
        instr_force = 1'b0;
        tick();

        // Random images and gap patterns
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 6);
            ws.delete();
            for (int i = 0; i < n; i++) ws.push_back(rand_word());
            do_start();
            send(build(ws, n), $urandom_range(0, 1) * 50, 1'b0);
            wait_end(100);
            tick();
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_boot_ctrl.md
Name: riscv_boot_ctrl

Overview:
- Load/run sequencer for the single-cycle RISC-V core.
- Accepts a length-prefixed byte stream and writes it word-by-word into the external instruction memory while the core is held in reset.
- Then releases the core, counts execution cycles, and stops the core on a halt instruction, a PC fault or a timeout.
- Sits between the host loader interface and the core/instruction-memory pair at top level.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
CYC_W, 16, cycle-counter width
MAX_CYCLES, 16'hFFFF, run-cycle limit before timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin load sequence (sampled in IDLE/HALT/ERR only)
s_valid  in  1  byte-stream valid
s_data  in  8  byte-stream data
s_ready  out  1  byte-stream ready
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  instruction-memory word address
imem_wdata  out  32  instruction-memory write data
core_run  out  1  1 = core released; 0 = core held in reset
pc  in  32  core PC (pc_out)
instr  in  32  instruction currently fetched by core
busy  out  1  high in HDR0/HDR1/LOAD/RUN
done  out  1  high in HALT
error  out  1  high in ERR
err_code  out  2  0 none, 1 bad length, 2 PC fault, 3 timeout
cycle_count  out  CYC_W  cycles spent in RUN

Behaviour:
- Reset (reset=0 at posedge): state IDLE; all outputs 0; byte/word counters and assembly register cleared. Applies mid-load or mid-run: core_run drops to 0 the following cycle.
- States: IDLE, HDR0, HDR1, LOAD, RUN, HALT, ERR. State and all outputs are registered.
- IDLE/HALT/ERR + start=1 -> HDR0:
  - Clears err_code, cycle_count and the word index.
  - HALT/ERR outputs are cleared on exit.
  - start in any other state is ignored.
- Handshake:
  - s_ready=1 only in HDR0, HDR1 and LOAD.
  - A byte transfers when s_valid & s_ready at posedge; s_data is ignored otherwise.
  - The source may hold s_valid arbitrarily long.
- HDR0: transfer captures N[7:0] -> HDR1. HDR1: transfer captures N[15:8], then:
  - N==0 or N>2^ADDR_W -> ERR, err_code=1.
  - Otherwise -> LOAD.
- LOAD byte assembly:
  - Bytes are little-endian, 4 per word.
  - On the 4th byte transfer, the next cycle has imem_we=1 for exactly one cycle, imem_wdata=assembled word, imem_addr=word index (0..N-1).
  - The index increments after the write. s_ready stays high, so back-to-back words are allowed.
  - imem_we=0 otherwise; imem_addr/imem_wdata hold their last values.
- Load-to-run transition:
  - After the write of word N-1, the next cycle enters RUN with core_run=1.
  - s_ready=0 in that cycle; extra stream bytes are not accepted.
- RUN:
  - cycle_count=0 on the first RUN cycle, then +1 per cycle, saturating at all-ones.
  - instr and pc are checked every RUN cycle, in priority order:
    1. Halt: instr==32'h00100073 (ebreak) or instr==32'h0000006F (jal x0,0) -> HALT.
    2. PC fault: pc[1:0]!=0 or pc[31:ADDR_W+2]!=0 -> ERR, err_code=2.
    3. Timeout: cycle_count==MAX_CYCLES -> ERR, err_code=3.
- HALT/ERR exit:
  - core_run=0 from the cycle HALT/ERR is entered.
  - cycle_count freezes at its value in the detecting cycle.
  - done or error is held until reset or start.
- Instruction-memory contents are never cleared by this block.

Test Plan:
1. Load N=2, words 0x00500093, 0x00100073 (bytes 02 00 93 00 50 00 73 00 10 00), s_valid held high -> two imem_we pulses, addr 0 then 1, correct wdata; core_run rises the cycle after the 2nd pulse; with the core modelled, HALT reached, done=1, core_run=0, cycle_count=1.
2. Header 00 00, then separately header 01 (0x0101 > 256 for ADDR_W=8) -> ERR, err_code=1, no imem_we, core_run stays 0.
3. Random s_valid gaps (~50% duty) during a 3-word load -> identical imem writes to the gap-free case; no byte lost or duplicated; s_ready=0 after the last word.
4. Run with instr held at 32'h00000013 and pc incrementing from 0, MAX_CYCLES=20 -> ERR, err_code=3, cycle_count=20, core_run=0.
5. During RUN drive pc=32'h00000402 -> ERR, err_code=2 next cycle. Then start=1 -> HDR0, error=0, err_code=0, cycle_count=0; a fresh load succeeds.
6. Assert reset=0 mid-LOAD (after 5 bytes) and mid-RUN -> next cycle IDLE, all outputs 0. Then start with a new stream -> word index restarts at 0.
